hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage 19-bit-instruction MIPS core. Sits beside the forwarding unit and decides every cycle whether PC/IF_ID advance, hold, or are bubbled/flushed.
- Covers the hazards forwarding cannot resolve: load-use, taken branch, and memory wait.
- Also keeps stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/hazard_stall_ctrl_if.sv | 35 +++
 rtl/hazard_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Handshake/bus bundle between the pipeline and its stall/flush controller.
// Master drives instruction/memory status, slave returns sequencing controls.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [18:0]      IF_ID_instruction;
  logic [18:0]      ID_EX_instruction;
  logic             branch_taken_EX;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             pipe_freeze;
  logic             mem_error;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IF_ID_instruction, ID_EX_instruction,
    output branch_taken_EX, mem_req, mem_ready,
    input  pc_write, IF_ID_write, IF_ID_flush,
    input  ID_EX_flush, pipe_freeze, mem_error,
    input  stall_count, flush_count
  );

  modport slave (
    input  IF_ID_instruction, ID_EX_instruction,
    input  branch_taken_EX, mem_req, mem_ready,
    output pc_write, IF_ID_write, IF_ID_flush,
    output ID_EX_flush, pipe_freeze, mem_error,
    output stall_count, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage 19-bit MIPS pipeline:
// load-use bubbles, taken-branch flushes, data-memory wait freeze.
module hazard_stall_ctrl #(
  parameter logic [4:0] LW_OPCODE         = 5'b10000,
  parameter logic [4:0] SW_OPCODE         = 5'b10001,
  parameter int         LOAD_STALL_CYCLES = 2,
  parameter int         MEM_TIMEOUT       = 255,
  parameter int         CNT_W             = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int SCW = $clog2(LOAD_STALL_CYCLES + 1);
  localparam int TW  = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } state_t;

  state_t           state, state_n;
  state_t           ret, ret_n;
  state_t           eff;
  logic [SCW-1:0]   scnt, scnt_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic             err, err_n;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             pc_w, ifid_w, ifid_f, idex_f, frz;

  logic [2:0] x_dst;
  logic       x_lw;
  logic       d_alu_rr;
  logic       hazard;

  assign x_dst    = bus.ID_EX_instruction[13:11];
  assign x_lw     = bus.ID_EX_instruction[18:14] == LW_OPCODE;
  assign d_alu_rr = !bus.IF_ID_instruction[18] &&
                    !bus.IF_ID_instruction[17];

  assign hazard = x_lw && (x_dst != 3'd0) && (
    (bus.IF_ID_instruction[10:8] == x_dst) ||
    (d_alu_rr && bus.IF_ID_instruction[7:5] == x_dst) ||
    (bus.IF_ID_instruction[18:14] == SW_OPCODE &&
     bus.IF_ID_instruction[13:11] == x_dst));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ret       <= RUN;
      scnt      <= '0;
      tcnt      <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      ret       <= ret_n;
      scnt      <= scnt_n;
      tcnt      <= tcnt_n;
      err       <= err_n;
      stall_cnt <= stall_cnt +
        CNT_W'(stall_inc && !(&stall_cnt));
      flush_cnt <= flush_cnt +
        CNT_W'(flush_inc && !(&flush_cnt));
    end
  end

  // A completing wait behaves exactly like the state it interrupted.
  always_comb begin
    eff = (state == MEM_WAIT && bus.mem_ready) ? ret : state;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    ifid_f    = 1'b0;
    idex_f    = 1'b0;
    frz       = 1'b0;
    state_n   = eff;
    ret_n     = ret;
    scnt_n    = scnt;
    tcnt_n    = tcnt;
    err_n     = err;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (state == MEM_WAIT && !bus.mem_ready) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      frz    = 1'b1;
      if (tcnt != TW'(MEM_TIMEOUT)) begin
        tcnt_n = tcnt + 1'b1;
        if (tcnt_n == TW'(MEM_TIMEOUT)) err_n = 1'b1;
      end
    end else if (bus.mem_req && !bus.mem_ready) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      frz     = 1'b1;
      state_n = MEM_WAIT;
      ret_n   = eff;
      tcnt_n  = '0;
    end else if (bus.branch_taken_EX) begin
      ifid_f    = 1'b1;
      idex_f    = 1'b1;
      flush_inc = 1'b1;
      state_n   = RUN;
    end else if (eff == LOAD_STALL) begin
      pc_w      = 1'b0;
      ifid_w    = 1'b0;
      idex_f    = 1'b1;
      stall_inc = 1'b1;
      scnt_n    = scnt - 1'b1;
      state_n   = (scnt == SCW'(1)) ? RUN : LOAD_STALL;
    end else if (hazard) begin
      pc_w      = 1'b0;
      ifid_w    = 1'b0;
      idex_f    = 1'b1;
      stall_inc = 1'b1;
      scnt_n    = SCW'(LOAD_STALL_CYCLES - 1);
      state_n   = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
    end
    if (rst) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      ifid_f = 1'b1;
      idex_f = 1'b1;
      frz    = 1'b0;
    end
  end

  assign bus.pc_write    = pc_w;
  assign bus.IF_ID_write = ifid_w;
  assign bus.IF_ID_flush = ifid_f;
  assign bus.ID_EX_flush = idex_f;
  assign bus.pipe_freeze = frz;
  assign bus.mem_error   = err;
  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed test-plan cases then random
// traffic, all cycles checked against a counter-based behavioural model.
module tb_hazard_stall_ctrl;

  localparam logic [4:0] LW  = 5'b10000;
  localparam logic [4:0] SWO = 5'b10001;
  localparam int         LSC = 2;
  localparam int         TMO = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();

  hazard_stall_ctrl #(
    .LW_OPCODE(LW), .SW_OPCODE(SWO),
    .LOAD_STALL_CYCLES(LSC), .MEM_TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // model: bubbles still owed, wait status, counts
  int m_pend = 0;
  bit m_wait = 0;
  int m_wlen = 0;
  bit m_err  = 0;
  int m_sc   = 0;
  int m_fc   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_hazard(input logic [18:0] d,
                                   input logic [18:0] x);
    logic [2:0] rd;
    bit         reads_b;
    rd = x[13:11];
    if (x[18:14] != LW || rd == 3'd0) return 0;
    if (d[10:8] == rd) return 1;
    reads_b = (d[18] == 1'b0) && (d[17] == 1'b0);
    if (reads_b && d[7:5] == rd) return 1;
    if (d[18:14] == SWO && d[13:11] == rd) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] a;
    bit hz;
    bit stall_wait;
    hz = is_hazard(bus.IF_ID_instruction, bus.ID_EX_instruction);
    stall_wait = bus.mem_req && !bus.mem_ready;
    if (rst)                            e = 5'b00110;
    else if (m_wait && !bus.mem_ready)  e = 5'b00001;
    else if (stall_wait)                e = 5'b00001;
    else if (bus.branch_taken_EX)       e = 5'b11110;
    else if (m_pend > 0 || hz)          e = 5'b00010;
    else                                e = 5'b11000;
    a = {bus.pc_write, bus.IF_ID_write, bus.IF_ID_flush,
         bus.ID_EX_flush, bus.pipe_freeze};
    chk("ctl{pc,ifw,iff,idf,frz}", 32'(a), 32'(e));
    chk("mem_error", 32'(bus.mem_error), 32'(m_err));
    chk("stall_count", 32'(bus.stall_count), 32'(m_sc));
    chk("flush_count", 32'(bus.flush_count), 32'(m_fc));
    if (rst) begin
      m_pend = 0; m_wait = 0; m_wlen = 0;
      m_err = 0; m_sc = 0; m_fc = 0;
    end else if (m_wait && !bus.mem_ready) begin
      m_wlen++;
      if (m_wlen >= TMO) m_err = 1;
    end else if (stall_wait) begin
      m_wait = 1;
      m_wlen = 0;
    end else begin
      m_wait = 0;
      if (bus.branch_taken_EX) begin
        m_pend = 0;
        if (m_fc < 65535) m_fc++;
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_sc < 65535) m_sc++;
      end else if (hz) begin
        m_pend = LSC - 1;
        if (m_sc < 65535) m_sc++;
      end
    end
  end

  function automatic logic [18:0] mk(input logic [4:0] op,
    input int dst, input int ra, input int rb);
    return {op, 3'(dst), 3'(ra), 3'(rb), 5'd0};
  endfunction

  function automatic logic [18:0] rnd_instr();
    logic [4:0] op;
    case ($urandom_range(0, 3))
      0:       op = LW;
      1:       op = SWO;
      2:       op = {2'b00, 3'($urandom_range(0, 7))};
      default: op = {2'b01, 3'($urandom_range(0, 7))};
    endcase
    return mk(op, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IF_ID_instruction = '0;
    bus.ID_EX_instruction = '0;
    bus.branch_taken_EX   = 1'b0;
    bus.mem_req           = 1'b0;
    bus.mem_ready         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // lw r3 then add r1,r3,r2
    bus.ID_EX_instruction = mk(LW, 3, 0, 0);
    bus.IF_ID_instruction = mk(5'b00000, 1, 3, 2);
    #1 chk("lu_c0_pc", 32'(bus.pc_write), 0);
    tick();
    bus.ID_EX_instruction = '0;
    #1 chk("lu_c1_pc", 32'(bus.pc_write), 0);
    chk("lu_c1_idf", 32'(bus.ID_EX_flush), 1);
    tick();
    #1 chk("lu_c2_pc", 32'(bus.pc_write), 1);
    chk("lu_stall2", 32'(bus.stall_count), 2);
    chk("model_sc2", 32'(m_sc), 2);

    // r0 destination and immediate B field never stall
    do_reset();
    bus.ID_EX_instruction = mk(LW, 0, 0, 0);
    bus.IF_ID_instruction = mk(5'b00000, 1, 0, 0);
    #1 chk("r0_pc", 32'(bus.pc_write), 1);
    tick();
    bus.ID_EX_instruction = mk(LW, 3, 0, 0);
    bus.IF_ID_instruction = mk(5'b01000, 1, 2, 3);
    #1 chk("imm_pc", 32'(bus.pc_write), 1);
    tick();
    #1 chk("r0_imm_sc", 32'(bus.stall_count), 0);

    // sw r3 after lw r3
    do_reset();
    bus.ID_EX_instruction = mk(LW, 3, 0, 0);
    bus.IF_ID_instruction = mk(SWO, 3, 1, 0);
    #1 chk("sw_c0_pc", 32'(bus.pc_write), 0);
    tick();
    bus.ID_EX_instruction = '0;
    #1 chk("sw_c1_pc", 32'(bus.pc_write), 0);
    tick();
    #1 chk("sw_c2_pc", 32'(bus.pc_write), 1);
    chk("sw_sc2", 32'(bus.stall_count), 2);

    // branch beats load-use
    do_reset();
    bus.ID_EX_instruction = mk(LW, 3, 0, 0);
    bus.IF_ID_instruction = mk(5'b00000, 1, 3, 2);
    bus.branch_taken_EX = 1'b1;
    #1 chk("br_ctl", 32'({bus.pc_write, bus.IF_ID_flush,
                          bus.ID_EX_flush}), 32'b111);
    tick();
    bus.branch_taken_EX = 1'b0;
    bus.ID_EX_instruction = '0;
    bus.IF_ID_instruction = '0;
    #1 chk("br_fc1", 32'(bus.flush_count), 1);
    chk("br_sc0", 32'(bus.stall_count), 0);
    chk("model_fc1", 32'(m_fc), 1);

    // memory wait during the load stall
    do_reset();
    bus.ID_EX_instruction = mk(LW, 3, 0, 0);
    bus.IF_ID_instruction = mk(5'b00000, 1, 3, 2);
    tick();
    bus.ID_EX_instruction = '0;
    bus.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("mw_freeze", 32'(bus.pipe_freeze), 1);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1 chk("mw_exit", 32'({bus.pipe_freeze, bus.pc_write,
                           bus.ID_EX_flush}), 32'b001);
    tick();
    bus.mem_req = 1'b0;
    bus.mem_ready = 1'b0;
    #1 chk("mw_run_pc", 32'(bus.pc_write), 1);
    chk("mw_sc2", 32'(bus.stall_count), 2);

    // timeout
    do_reset();
    bus.mem_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        #1 chk("to_not_yet", 32'(bus.mem_error), 0);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    #1 chk("to_set", 32'(bus.mem_error), 1);
    chk("model_err", 32'(m_err), 1);
    tick();
    bus.mem_req = 1'b0;
    bus.mem_ready = 1'b0;
    #1 chk("to_sticky", 32'(bus.mem_error), 1);
    rst = 1'b1;
    #1 chk("rst_ctl", 32'({bus.pc_write, bus.IF_ID_flush}), 32'b01);
    tick();
    rst = 1'b0;
    #1 chk("rst_err", 32'(bus.mem_error), 0);
    chk("rst_cnt", 32'({bus.stall_count, bus.flush_count}), 0);
    chk("rst_run_pc", 32'(bus.pc_write), 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      bus.ID_EX_instruction = rnd_instr();
      bus.IF_ID_instruction = rnd_instr();
      bus.branch_taken_EX = ($urandom_range(0, 9) == 0);
      bus.mem_req = ($urandom_range(0, 7) == 0);
      bus.mem_ready = ($urandom_range(0, 9) < 6);
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
